// File: rtl/uart_rx_multi.sv
// uart_rx_multi: parametrised UART receiver with majority-vote sampling,
// framing/overrun detection and a one-entry valid/ready output register.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_multi #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned Div   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned TickW = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned SampW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_s;
  logic [TickW-1:0]     tick_cnt_q;
  logic [SampW-1:0]     samp_cnt_q;
  logic                 samp0_q, samp1_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [BitW-1:0]      bit_cnt_q;
  logic                 stop_cnt_q;
  logic                 ferr_acc_q;
  logic                 data_valid_q, frame_err_q, overrun_q;
  logic [DATA_BITS-1:0] data_out_q;
  logic                 tick, vote, bit_end, voted, complete, word_ferr;

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s      <= rx_meta_q;
    end
  end

  assign tick    = (state_q != StIdle) && (state_q != StBreak) && (tick_cnt_q == TickW'(Div - 1));
  assign vote    = tick && (samp_cnt_q == SampW'(OVERSAMPLE / 2 + 1));
  assign bit_end = tick && (samp_cnt_q == SampW'(OVERSAMPLE - 1));
  // Third sample is taken live at the vote tick.
  assign voted   = (samp0_q & samp1_q) | (samp0_q & rx_s) | (samp1_q & rx_s);
  assign word_ferr = ferr_acc_q | ~voted;

  // Tick and sample counters; held at zero while idle so the start edge restarts them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
      samp_cnt_q <= '0;
      samp0_q    <= 1'b1;
      samp1_q    <= 1'b1;
    end else if (state_q == StIdle || state_q == StBreak) begin
      tick_cnt_q <= '0;
      samp_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
      samp_cnt_q <= bit_end ? '0 : samp_cnt_q + 1'b1;
      if (samp_cnt_q == SampW'(OVERSAMPLE / 2 - 1)) samp0_q <= rx_s;
      if (samp_cnt_q == SampW'(OVERSAMPLE / 2))     samp1_q <= rx_s;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic and word-completion strobe.
  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    unique case (state_q)
      StIdle:  if (!rx_s) state_d = StStart;
      StStart: begin
        if (vote && voted) state_d = StIdle;
        else if (bit_end)  state_d = StData;
      end
      StData: begin
        if (bit_end && bit_cnt_q == BitW'(DATA_BITS)) begin
`ifdef UART_RX_PARITY_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end
      end
      StParity: begin
`ifdef UART_RX_PARITY_EN
        if (bit_end) state_d = StStop;
`else
        state_d = StIdle;
`endif
      end
      StStop: begin
        if (vote && stop_cnt_q == 1'(STOP_BITS - 1)) begin
          complete = 1'b1;
          state_d  = word_ferr ? StBreak : StIdle;
        end
      end
      StBreak: if (rx_s) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Frame datapath: shift register, bit/stop counters, error accumulators.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      ferr_acc_q <= 1'b0;
    end else if (state_q == StIdle) begin
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      ferr_acc_q <= 1'b0;
    end else if (state_q == StData && vote) begin
      shreg_q   <= {voted, shreg_q[DATA_BITS-1:1]};
      bit_cnt_q <= bit_cnt_q + 1'b1;
    end else if (state_q == StStop) begin
      if (vote)    ferr_acc_q <= word_ferr;
      if (bit_end) stop_cnt_q <= stop_cnt_q + 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic perr_acc_q, parity_err_q;

  // Parity mismatch: received bit versus XOR (even) or XNOR (odd) of the data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perr_acc_q   <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      if (state_q == StIdle) perr_acc_q <= 1'b0;
      else if (state_q == StParity && vote)
        perr_acc_q <= voted ^ (^shreg_q) ^ 1'(PARITY_ODD);
      if (complete && (!data_valid_q || data_ready)) parity_err_q <= perr_acc_q;
    end
  end
  assign parity_err = parity_err_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
  assign parity_err = 1'b0;
`endif

  // One-entry holding register; a completed word is dropped if the slot is still full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (complete) begin
        if (!data_valid_q || data_ready) begin
          data_out_q   <= shreg_q;
          frame_err_q  <= word_ferr;
          data_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (data_valid_q && data_ready) begin
        data_valid_q <= 1'b0;
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_multi.sv
// Directed testbench for uart_rx_multi. A fast line rate keeps the run short:
// 100 MHz / (1 Mbaud * 16) gives a 6-clock tick and a 96-clock bit.
module tb_uart_rx_multi;

  localparam int unsigned ClkFreq = 100_000_000;
  localparam int unsigned Baud    = 1_000_000;
  localparam int unsigned Os      = 16;
  localparam int          BitClks = 96;
`ifdef UART_RX_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_drv = 1'b1;
  logic       sel7 = 1'b0;
  logic       data_ready = 1'b0;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid, frame_err, parity_err, overrun, busy;

  int n_vec = 0;
  int n_err = 0;

  // Observation counters updated by the monitor.
  int         acc_cnt = 0;
  int         valid_cycles = 0;
  int         ovr_cnt = 0;
  logic [7:0] last_word = '0;
  logic       last_ferr = 1'b0;
  logic       last_perr = 1'b0;

  assign rx = sel7 ? 1'b1 : rx_drv;

  always #5 clk = ~clk;

  uart_rx_multi #(
    .CLK_FREQ  (ClkFreq),
    .BAUD_RATE (Baud),
    .DATA_BITS (8),
    .STOP_BITS (1),
    .OVERSAMPLE(Os),
    .PARITY_ODD(0)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (data_valid) valid_cycles <= valid_cycles + 1;
    if (overrun)    ovr_cnt <= ovr_cnt + 1;
    if (data_valid && data_ready) begin
      acc_cnt   <= acc_cnt + 1;
      last_word <= data_out;
      last_ferr <= frame_err;
      last_perr <= parity_err;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic       rx7;
  logic [6:0] data_out7;
  logic       data_valid7, frame_err7, parity_err7, overrun7, busy7;
  logic [6:0] last_word7 = '0;
  logic       last_perr7 = 1'b0;

  assign rx7 = sel7 ? rx_drv : 1'b1;

  uart_rx_multi #(
    .CLK_FREQ  (ClkFreq),
    .BAUD_RATE (Baud),
    .DATA_BITS (7),
    .STOP_BITS (1),
    .OVERSAMPLE(Os),
    .PARITY_ODD(0)
  ) u_dut7 (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx7),
    .data_out  (data_out7),
    .data_valid(data_valid7),
    .data_ready(data_ready),
    .frame_err (frame_err7),
    .parity_err(parity_err7),
    .overrun   (overrun7),
    .busy      (busy7)
  );

  always @(negedge clk) begin
    if (data_valid7 && data_ready) begin
      last_word7 <= data_out7;
      last_perr7 <= parity_err7;
    end
  end
`endif

  // One bit period; optionally inverts a 5-clock window around the middle sample.
  task automatic drive_bit(input logic val, input bit flip);
    rx_drv = val;
    if (flip) begin
      repeat (52) @(negedge clk);
      rx_drv = ~val;
      repeat (5) @(negedge clk);
      rx_drv = val;
      repeat (BitClks - 57) @(negedge clk);
    end else begin
      repeat (BitClks) @(negedge clk);
    end
  endtask

  // Full frame; rx is left at stop_val when the task returns.
  task automatic send_frame(input logic [8:0] data, input int nbits, input bit has_par,
                            input logic par_bit, input logic stop_val, input int flip_bit);
    @(negedge clk);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(data[i], i == flip_bit);
    if (has_par) drive_bit(par_bit, 1'b0);
    drive_bit(stop_val, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val, input int flip_bit);
    send_frame({1'b0, b}, 8, ParEn, ^b, stop_val, flip_bit);
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (1000) @(negedge clk);
    n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_data got %h exp 00", data_out); end
    n_vec++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", data_valid); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
    n_vec++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL reset_perr got %b exp 0", parity_err); end
    n_vec++; if (overrun !== 1'b0 || ovr_cnt != 0) begin
      n_err++; $display("FAIL reset_overrun got %b/%0d exp 0/0", overrun, ovr_cnt);
    end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_basic();
    int acc0, vc0;
    data_ready = 1'b1;
    acc0 = acc_cnt; vc0 = valid_cycles;
    send_byte(8'hA5, 1'b1, -1);
    repeat (10) @(negedge clk);
    n_vec++; if (acc_cnt != acc0 + 1) begin n_err++; $display("FAIL a5_count got %0d exp %0d", acc_cnt - acc0, 1); end
    n_vec++; if (last_word !== 8'hA5) begin n_err++; $display("FAIL a5_data got %h exp a5", last_word); end
    n_vec++; if (last_ferr !== 1'b0 || last_perr !== 1'b0) begin
      n_err++; $display("FAIL a5_errs got %b%b exp 00", last_ferr, last_perr);
    end
    n_vec++; if (valid_cycles != vc0 + 1) begin
      n_err++; $display("FAIL a5_valid_width got %0d exp 1", valid_cycles - vc0);
    end
  endtask

  task automatic test_framing();
    int acc0;
    data_ready = 1'b1;
    acc0 = acc_cnt;
    send_byte(8'h3C, 1'b0, -1);
    repeat (20 * BitClks) @(negedge clk);
    n_vec++; if (acc_cnt != acc0 + 1) begin n_err++; $display("FAIL ferr_count got %0d exp 1", acc_cnt - acc0); end
    n_vec++; if (last_word !== 8'h3C) begin n_err++; $display("FAIL ferr_data got %h exp 3c", last_word); end
    n_vec++; if (last_ferr !== 1'b1) begin n_err++; $display("FAIL ferr_flag got %b exp 1", last_ferr); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL break_busy got %b exp 1", busy); end
    rx_drv = 1'b1;
    repeat (2 * BitClks) @(negedge clk);
    n_vec++; if (acc_cnt != acc0 + 1 || busy !== 1'b0) begin
      n_err++; $display("FAIL break_release got %0d/%b exp 1/0", acc_cnt - acc0, busy);
    end
    send_byte(8'h55, 1'b1, -1);
    repeat (10) @(negedge clk);
    n_vec++; if (last_word !== 8'h55 || last_ferr !== 1'b0 || acc_cnt != acc0 + 2) begin
      n_err++; $display("FAIL after_break got %h/%b/%0d exp 55/0/2", last_word, last_ferr, acc_cnt - acc0);
    end
  endtask

  task automatic test_overrun();
    int acc0, ovr0;
    data_ready = 1'b0;
    acc0 = acc_cnt; ovr0 = ovr_cnt;
    send_byte(8'h11, 1'b1, -1);
    send_byte(8'h22, 1'b1, -1);
    repeat (10) @(negedge clk);
    n_vec++; if (data_valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid got %b exp 1", data_valid); end
    n_vec++; if (data_out !== 8'h11) begin n_err++; $display("FAIL ovr_hold got %h exp 11", data_out); end
    n_vec++; if (ovr_cnt != ovr0 + 1) begin n_err++; $display("FAIL ovr_pulse got %0d exp 1", ovr_cnt - ovr0); end
    data_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL ovr_drop got %b exp 0", data_valid); end
    n_vec++; if (last_word !== 8'h11 || acc_cnt != acc0 + 1) begin
      n_err++; $display("FAIL ovr_accept got %h/%0d exp 11/1", last_word, acc_cnt - acc0);
    end
    repeat (BitClks) @(negedge clk);
    n_vec++; if (acc_cnt != acc0 + 1) begin n_err++; $display("FAIL ovr_lost got %0d exp 1", acc_cnt - acc0); end
  endtask

  task automatic test_glitch();
    int acc0, vc0;
    data_ready = 1'b1;
    acc0 = acc_cnt; vc0 = valid_cycles;
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (BitClks / 4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (10) @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL glitch_start got %b exp 1", busy); end
    repeat (2 * BitClks) @(negedge clk);
    n_vec++; if (busy !== 1'b0 || acc_cnt != acc0 || valid_cycles != vc0) begin
      n_err++; $display("FAIL glitch_idle got %b/%0d/%0d exp 0/0/0", busy, acc_cnt - acc0,
                        valid_cycles - vc0);
    end
  endtask

  task automatic test_majority();
    data_ready = 1'b1;
    send_byte(8'h96, 1'b1, 3);
    repeat (10) @(negedge clk);
    n_vec++; if (last_word !== 8'h96) begin n_err++; $display("FAIL vote_bit3 got %h exp 96", last_word); end
    send_byte(8'h96, 1'b1, 7);
    repeat (10) @(negedge clk);
    n_vec++; if (last_word !== 8'h96) begin n_err++; $display("FAIL vote_bit7 got %h exp 96", last_word); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    data_ready = 1'b1;
    sel7 = 1'b1;
    // 0x41 has two ones, so even parity expects 0.
    send_frame(9'h041, 7, 1'b1, 1'b1, 1'b1, -1);
    repeat (10) @(negedge clk);
    n_vec++; if (last_word7 !== 7'h41 || last_perr7 !== 1'b1) begin
      n_err++; $display("FAIL parity_bad got %h/%b exp 41/1", last_word7, last_perr7);
    end
    send_frame(9'h041, 7, 1'b1, 1'b0, 1'b1, -1);
    repeat (10) @(negedge clk);
    n_vec++; if (last_word7 !== 7'h41 || last_perr7 !== 1'b0) begin
      n_err++; $display("FAIL parity_good got %h/%b exp 41/0", last_word7, last_perr7);
    end
    sel7 = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_framing();
    test_overrun();
    test_glitch();
    test_majority();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
